piso_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one parallel-in/serial-out serializer among NREQ parallel word requesters. Each requester offers a WIDTH-bit word with a valid/ready handshake. The scheduler grants one word at a time, shifts it out LSB-first on a single serial valid/ready link, and tags the link with the source channel. It sits between the per-channel FIFO read sides and the serial transmit link, on a single clock domain.

---
 rtl/piso_rr_scheduler_if.sv | 65 ++++++
 rtl/piso_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_piso_rr_scheduler.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// piso_rr_scheduler_if
//
// Bundles the handshake signals of piso_rr_scheduler: the NREQ parallel
// word requesters on one side and the single serial valid/ready link on the
// other. Signal names keep the scheduler's own port names so existing
// connections map one-to-one.
//
// Signals:
//   req_valid_i [NREQ]        per-channel word valid
//   req_data_i  [NREQ*WIDTH]  per-channel words, channel k at [k*WIDTH +: WIDTH]
//   req_ready_o [NREQ]        per-channel accept, at most one bit high
//   d_o                       serial data bit (LSB first)
//   valid_o                   serial bit valid
//   ready_i                   serial sink accepts the current bit
//   sof_o / eof_o             current bit is bit 0 / bit WIDTH-1 of a word
//   chan_o      [IDW]         source channel of the word being shifted
//   busy_o                    a word is loaded (equals valid_o)
//
// Modports:
//   slave  - scheduler view
//   master - environment view (requesters + serial sink)
// ---------------------------------------------------------------------------
interface piso_rr_scheduler_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic [NREQ-1:0]       req_ready_o;
    logic                  d_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  sof_o;
    logic                  eof_o;
    logic [IDW-1:0]        chan_o;
    logic                  busy_o;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  ready_i,
        output req_ready_o,
        output d_o,
        output valid_o,
        output sof_o,
        output eof_o,
        output chan_o,
        output busy_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output ready_i,
        input  req_ready_o,
        input  d_o,
        input  valid_o,
        input  sof_o,
        input  eof_o,
        input  chan_o,
        input  busy_o
    );
endinterface

// File: rtl/piso_rr_scheduler.sv
// ---------------------------------------------------------------------------
// piso_rr_scheduler
//
// Round-robin scheduler sharing one parallel-in/serial-out shifter among
// NREQ word requesters. One word is granted at a time, shifted out LSB first
// on a valid/ready serial link and tagged with its source channel. When the
// last bit of a word is accepted the next word can be loaded in the same
// cycle, so a continuously fed link carries one bit per clock with no gaps.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active low
//   bus    - piso_rr_scheduler_if.slave (requester and serial link signals)
//
// Parameters:
//   WIDTH  - bits per word (>= 2)
//   NREQ   - number of requesters (2..16)
//   IDW    - channel id width, clog2(NREQ)
// ---------------------------------------------------------------------------
module piso_rr_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    piso_rr_scheduler_if.slave bus
);

    localparam int unsigned    CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [IDW-1:0] CHAN_LAST = IDW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [IDW-1:0]   ptr_q,   ptr_d;
    logic [IDW-1:0]   chan_q,  chan_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] word_w [NREQ];
    logic             shifting;
    logic             last_bit;
    logic             window_open;
    logic             any_valid;
    logic [IDW-1:0]   grant_idx;
    logic             load;
    int unsigned      search_idx;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign word_w[k] = bus.req_data_i[k*WIDTH +: WIDTH];
    end

    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = shifting && (cnt_q == CNT_LAST);

    // A new word may be taken when nothing is loaded, or when the final bit
    // of the current word is being accepted this very cycle.
    assign window_open = !shifting || (last_bit && bus.ready_i);

    // Rotating priority search starting at ptr_q. The index is folded back
    // explicitly so that NREQ need not be a power of two.
    always_comb begin
        any_valid  = 1'b0;
        grant_idx  = '0;
        search_idx = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            search_idx = 32'(ptr_q) + i;
            if (search_idx >= NREQ) begin
                search_idx = search_idx - NREQ;
            end
            if (!any_valid && bus.req_valid_i[IDW'(search_idx)]) begin
                any_valid = 1'b1;
                grant_idx = IDW'(search_idx);
            end
        end
    end

    // rst_i gates the grant so req_ready_o is quiet for the whole time reset
    // is held, not just after the first edge.
    assign load = rst_i && window_open && any_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;

        if (load) begin
            state_d = ST_SHIFT;
            shreg_d = word_w[grant_idx];
            cnt_d   = '0;
            chan_d  = grant_idx;
            ptr_d   = (grant_idx == CHAN_LAST) ? '0 : grant_idx + 1'b1;
        end else if (shifting && bus.ready_i) begin
            if (last_bit) begin
                state_d = ST_IDLE;
            end else begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (serial side derived only from registered state)
    // ------------------------------------------------------------------
    assign bus.req_ready_o = load ? (NREQ'(1) << grant_idx) : '0;
    assign bus.d_o         = shifting && shreg_q[0];
    assign bus.valid_o     = shifting;
    assign bus.busy_o      = shifting;
    assign bus.sof_o       = shifting && (cnt_q == '0);
    assign bus.eof_o       = last_bit;
    assign bus.chan_o      = chan_q;

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_piso_rr_scheduler
//
// Directed scenarios followed by a randomized run checked against a
// word-level scoreboard of granted words and rotating-priority arbitration.
// ---------------------------------------------------------------------------
module tb_piso_rr_scheduler;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic clk;
    logic rst_n;

    logic [N-1:0] tb_valid;
    logic [W-1:0] tb_data [N];
    logic         tb_ready;

    int n_cmp;
    int n_fail;

    piso_rr_scheduler_if #(.WIDTH(W), .NREQ(N), .IDW(IDW)) bus ();

    piso_rr_scheduler #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        bus.req_valid_i = tb_valid;
        for (int k = 0; k < N; k++) begin
            bus.req_data_i[k*W +: W] = tb_data[k];
        end
        bus.ready_i = tb_ready;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tb_valid = '0;
        tb_ready = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n    = 1'b0;
        tb_valid = '1;
        tb_ready = 1'b1;
        for (int k = 0; k < N; k++) tb_data[k] = W'(k + 1);
        drive();
        #2;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready_o);
        end
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs got v%b b%b d%b s%b e%b c%0d exp all 0",
                               bus.valid_o, bus.busy_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant got %b exp 0001", bus.req_ready_o);
        end
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_valid got %b exp 0", bus.valid_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_word();
        logic [W-1:0] word;
        word = 8'hA5;
        @(negedge clk);
        tb_valid = 4'b0010; tb_data[1] = word; tb_ready = 1'b1; drive();
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0010) begin
            n_fail++; $display("FAIL single_grant got %b exp 0010", bus.req_ready_o);
        end
        for (int b = 0; b < W; b++) begin
            @(negedge clk);
            tb_valid = '0; drive();
            #1;
            n_cmp++;
            if ({bus.valid_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o} !==
                {1'b1, word[b], b == 0, b == W - 1, 2'd1}) begin
                n_fail++; $display("FAIL single_bit%0d got v%b d%b s%b e%b c%0d exp v1 d%b s%b e%b c1",
                                   b, bus.valid_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o,
                                   word[b], b == 0, b == W - 1);
            end
            n_cmp++;
            if (bus.req_ready_o !== 4'b0000) begin
                n_fail++; $display("FAIL single_ready_bit%0d got %b exp 0000", b, bus.req_ready_o);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.sof_o, bus.eof_o, bus.d_o} !== 5'b0) begin
            n_fail++; $display("FAIL single_idle got v%b b%b s%b e%b d%b exp 0",
                               bus.valid_o, bus.busy_o, bus.sof_o, bus.eof_o, bus.d_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_all_channels();
        logic [W-1:0] dat;
        int           word_no;
        int           cur_chan;
        int           valid_run;
        for (int k = 0; k < N; k++) tb_data[k] = W'($urandom);
        @(negedge clk);
        tb_valid = '1; tb_ready = 1'b1; drive();
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0001) begin
            n_fail++; $display("FAIL all_first_grant got %b exp 0001", bus.req_ready_o);
        end
        word_no   = 0;
        cur_chan  = 0;
        valid_run = 0;
        for (int c = 1; c <= 8 * W; c++) begin
            @(negedge clk);
            if (c == 8 * W) tb_valid = '0;
            drive();
            #1;
            if (bus.valid_o === 1'b1) valid_run++;
            if (bus.sof_o === 1'b1) begin
                cur_chan = word_no % N;
                n_cmp++;
                if (bus.chan_o !== IDW'(cur_chan)) begin
                    n_fail++; $display("FAIL all_chan word%0d got %0d exp %0d", word_no, bus.chan_o, cur_chan);
                end
                word_no++;
            end
            dat = tb_data[cur_chan];
            n_cmp++;
            if (bus.d_o !== dat[(c - 1) % W]) begin
                n_fail++; $display("FAIL all_data cycle%0d got %b exp %b", c, bus.d_o, dat[(c - 1) % W]);
            end
        end
        n_cmp++;
        if (valid_run != 8 * W) begin
            n_fail++; $display("FAIL all_valid_run got %0d exp %0d", valid_run, 8 * W);
        end
        n_cmp++;
        if (word_no != 8) begin
            n_fail++; $display("FAIL all_word_count got %0d exp 8", word_no);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL all_idle got %b exp 0", bus.valid_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [W-1:0] word;
        int           bitn;
        int           stall;
        int           cycles;
        word = 8'h3C;
        @(negedge clk);
        tb_valid = 4'b0100; tb_data[2] = word; tb_ready = 1'b1; drive();
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0100) begin
            n_fail++; $display("FAIL bp_grant got %b exp 0100", bus.req_ready_o);
        end
        bitn   = 0;
        stall  = 0;
        cycles = 0;
        while (bitn < W && cycles < 40) begin
            @(negedge clk);
            tb_valid = '0;
            tb_ready = !((bitn == 0 || bitn == 4) && stall < 3);
            drive();
            #1;
            cycles++;
            n_cmp++;
            if ({bus.valid_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o} !==
                {1'b1, word[bitn], bitn == 0, bitn == W - 1, 2'd2}) begin
                n_fail++; $display("FAIL bp_bit%0d cycle%0d got v%b d%b s%b e%b c%0d exp v1 d%b s%b e%b c2",
                                   bitn, cycles, bus.valid_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o,
                                   word[bitn], bitn == 0, bitn == W - 1);
            end
            if (tb_ready) begin
                bitn++;
                stall = 0;
            end else begin
                stall++;
            end
        end
        n_cmp++;
        if (cycles != 14) begin
            n_fail++; $display("FAIL bp_total_cycles got %0d exp 14", cycles);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle got %b exp 0", bus.valid_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_fairness();
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        tb_valid = 4'b1000; tb_data[3] = 8'h11; tb_ready = 1'b1; drive();
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b1000) begin
            n_fail++; $display("FAIL fair_ch3 got %b exp 1000", bus.req_ready_o);
        end
        tb_data[0] = 8'h22; tb_data[2] = 8'h44; tb_data[1] = 8'h33;
        for (int c = 1; c <= 3 * W; c++) begin
            @(negedge clk);
            tb_valid[3] = (c >= 2 * W + 1);
            tb_valid[1] = (c >= 2 * W + 1);
            tb_valid[0] = (c <= W);
            tb_valid[2] = (c <= 2 * W);
            drive();
            #1;
            exp_rdy = (c == W) ? 4'b0001 : (c == 2 * W) ? 4'b0100 : (c == 3 * W) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (bus.req_ready_o !== exp_rdy) begin
                n_fail++; $display("FAIL fair_ready cycle%0d got %b exp %b", c, bus.req_ready_o, exp_rdy);
            end
            if (c == W + 1 || c == 2 * W + 1) begin
                n_cmp++;
                if ({bus.sof_o, bus.chan_o} !== {1'b1, (c == W + 1) ? 2'd0 : 2'd2}) begin
                    n_fail++; $display("FAIL fair_chan cycle%0d got s%b c%0d exp s1 c%0d",
                                       c, bus.sof_o, bus.chan_o, (c == W + 1) ? 0 : 2);
                end
            end
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        @(negedge clk);
        tb_valid = 4'b0010; tb_data[1] = W'($urandom); tb_ready = 1'b1; drive();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tb_valid = '0; drive();
        end
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.chan_o} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL arst_pre got v%b c%0d exp v1 c1", bus.valid_o, bus.chan_o);
        end
        #1;
        rst_n    = 1'b0;
        tb_valid = 4'b1100;
        drive();
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.busy_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o, bus.req_ready_o} !== 11'b0) begin
            n_fail++; $display("FAIL arst_outputs got v%b b%b d%b s%b e%b c%0d r%b exp all 0",
                               bus.valid_o, bus.busy_o, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o,
                               bus.req_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0100) begin
            n_fail++; $display("FAIL arst_regrant got %b exp 0100", bus.req_ready_o);
        end
        @(negedge clk);
        tb_valid = '0; drive();
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.sof_o, bus.chan_o} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL arst_new_word got v%b s%b c%0d exp v1 s1 c2",
                               bus.valid_o, bus.sof_o, bus.chan_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        @(negedge clk);
        tb_valid = 4'b0010; tb_data[1] = 8'h5A; tb_data[0] = 8'hC3; tb_ready = 1'b1; drive();
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            tb_valid = 4'b0001; drive();
            #1;
            n_cmp++;
            if (bus.req_ready_o !== ((c == W) ? 4'b0001 : 4'b0000)) begin
                n_fail++; $display("FAIL b2b_ready cycle%0d got %b exp %b", c, bus.req_ready_o,
                                   (c == W) ? 4'b0001 : 4'b0000);
            end
        end
        n_cmp++;
        if (bus.eof_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_eof got %b exp 1", bus.eof_o);
        end
        @(negedge clk);
        tb_valid = '0; drive();
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.sof_o, bus.chan_o, bus.d_o} !== {1'b1, 1'b1, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_next got v%b s%b c%0d d%b exp v1 s1 c0 d1",
                               bus.valid_o, bus.sof_o, bus.chan_o, bus.d_o);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: granted words queue in order; the head word is expected on
    // the link bit by bit. Grants follow the rotating-priority rule.
    task automatic test_random();
        logic [W-1:0] exp_word_q[$];
        int           exp_chan_q[$];
        int           bitidx;
        int           mptr;
        logic [N-1:0] granted;
        logic         busy_exp;
        logic         window;
        logic         found;
        int           g;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] head;
        bitidx  = 0;
        mptr    = 0;
        granted = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (granted[k]) begin
                    tb_valid[k] = 1'b0;
                end else if (!tb_valid[k] && ($urandom % 3 == 0)) begin
                    tb_valid[k] = 1'b1;
                    tb_data[k]  = W'($urandom);
                end else if (tb_valid[k] && ($urandom % 25 == 0)) begin
                    tb_valid[k] = 1'b0;
                end
            end
            granted  = '0;
            tb_ready = ($urandom % 4) != 0;
            drive();
            #1;
            busy_exp = exp_word_q.size() > 0;
            n_cmp++;
            if ({bus.valid_o, bus.busy_o} !== {busy_exp, busy_exp}) begin
                n_fail++; $display("FAIL rand_valid cycle%0d got v%b b%b exp %b",
                                   cyc, bus.valid_o, bus.busy_o, busy_exp);
            end
            if (busy_exp) begin
                head = exp_word_q[0];
                n_cmp++;
                if ({bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o} !==
                    {head[bitidx], bitidx == 0, bitidx == W - 1, IDW'(exp_chan_q[0])}) begin
                    n_fail++; $display("FAIL rand_bit cycle%0d got d%b s%b e%b c%0d exp d%b s%b e%b c%0d",
                                       cyc, bus.d_o, bus.sof_o, bus.eof_o, bus.chan_o,
                                       head[bitidx], bitidx == 0, bitidx == W - 1, exp_chan_q[0]);
                end
            end else begin
                n_cmp++;
                if ({bus.d_o, bus.sof_o, bus.eof_o} !== 3'b000) begin
                    n_fail++; $display("FAIL rand_idle cycle%0d got d%b s%b e%b exp 000",
                                       cyc, bus.d_o, bus.sof_o, bus.eof_o);
                end
            end
            window = !busy_exp || (tb_ready && bitidx == W - 1);
            found  = 1'b0;
            g      = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && tb_valid[(mptr + i) % N]) begin
                    found = 1'b1;
                    g     = (mptr + i) % N;
                end
            end
            exp_rdy = (window && found) ? (N'(1) << g) : '0;
            n_cmp++;
            if (bus.req_ready_o !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready cycle%0d got %b exp %b", cyc, bus.req_ready_o, exp_rdy);
            end
            if (busy_exp && tb_ready) begin
                bitidx++;
                if (bitidx == W) begin
                    bitidx = 0;
                    void'(exp_word_q.pop_front());
                    void'(exp_chan_q.pop_front());
                end
            end
            if (window && found) begin
                exp_word_q.push_back(tb_data[g]);
                exp_chan_q.push_back(g);
                mptr       = (g + 1) % N;
                granted[g] = 1'b1;
            end
        end
        do_reset();
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        tb_valid = '0;
        tb_ready = 1'b0;
        for (int k = 0; k < N; k++) tb_data[k] = '0;
        rst_n = 1'b0;
        drive();
        test_reset();
        test_single_word();
        test_all_channels();
        test_backpressure();
        test_fairness();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
